// File: rtl/instr_mem_sync.sv
// rtl/instr_mem_sync.sv - Synchronous instruction memory with program-load port and fetch fault reporting
//
// Ports:
//   clk_i        in   1       clock, rising-edge active
//   rst_i        in   1       asynchronous active-low reset
//   req_i        in   1       fetch request
//   pc_addr_i    in   ADDR_W  fetch byte address
//   stall_i      in   1       hold outputs, ignore req_i
//   instr_o      out  DATA_W  fetched instruction (0 on a faulted fetch)
//   valid_o      out  1       instr_o holds a fetch result
//   fault_o      out  2       bit0 misaligned, bit1 out-of-range
//   ld_en_i      in   1       program-load write enable
//   ld_addr_i    in   ADDR_W  load byte address
//   ld_data_i    in   DATA_W  load data
//   fetch_cnt_o  out  16      saturating count of good fetches
module instr_mem_sync #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] pc_addr_i,
    input  logic              stall_i,
    output logic [DATA_W-1:0] instr_o,
    output logic              valid_o,
    output logic [1:0]        fault_o,
    input  logic              ld_en_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic [15:0]       fetch_cnt_o
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((DATA_W / 8) - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

    // Memory is not touched by reset, so its time-zero contents come from
    // the declaration initialiser.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic [ADDR_W-1:0] f_word;
    logic [ADDR_W-1:0] l_word;
    logic [IDX_W-1:0]  f_idx;
    logic [IDX_W-1:0]  l_idx;
    logic              f_mis;
    logic              f_oor;
    logic              l_ok;
    logic [DATA_W-1:0] rd_data;

    logic [DATA_W-1:0] instr_q;
    logic              valid_q;
    logic [1:0]        fault_q;
    logic [15:0]       cnt_q;

    assign f_word = pc_addr_i >> OFF_W;
    assign l_word = ld_addr_i >> OFF_W;
    assign f_idx  = f_word[IDX_W-1:0];
    assign l_idx  = l_word[IDX_W-1:0];
    assign f_mis  = (pc_addr_i & OFF_MASK) != '0;
    assign f_oor  = f_word >= DEPTH_A;
    assign l_ok   = ld_en_i && ((ld_addr_i & OFF_MASK) == '0) && (l_word < DEPTH_A);

    // Write-first: a load to the fetched word in the same cycle forwards
    // the new data rather than the stale array contents.
    assign rd_data = (l_ok && (l_idx == f_idx)) ? ld_data_i : mem[f_idx];

    // Loads share the reset-qualified block so they are naturally blocked
    // while reset is held; the reset branch leaves mem alone.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            instr_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 2'b00;
            cnt_q   <= 16'h0000;
        end else begin
            if (l_ok) begin
                mem[l_idx] <= ld_data_i;
            end
            if (!stall_i) begin
                if (req_i) begin
                    valid_q <= 1'b1;
                    fault_q <= {f_oor, f_mis};
                    if (f_mis || f_oor) begin
                        instr_q <= '0;
                    end else begin
                        instr_q <= rd_data;
                        if (cnt_q != 16'hFFFF) begin
                            cnt_q <= cnt_q + 16'h0001;
                        end
                    end
                end else begin
                    // Idle cycle: instr_q deliberately keeps its last value.
                    valid_q <= 1'b0;
                    fault_q <= 2'b00;
                end
            end
        end
    end

    assign instr_o     = instr_q;
    assign valid_o     = valid_q;
    assign fault_o     = fault_q;
    assign fetch_cnt_o = cnt_q;

endmodule

// File: doc/instr_mem_sync.md
INSTR_MEM_SYNC -- requirements
Module: instr_mem_sync

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 32, instruction word width in bits (multiple of 8).
REQ-002 The block SHALL provide parameter DEPTH, default 32, number of words (power of 2, >= 2).
REQ-003 The block SHALL provide parameter ADDR_W, default 32, byte-address width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clk_i and rst_i.
REQ-005 The block SHALL provide port clk_i  input  1  clock, rising-edge active.
REQ-006 The block SHALL provide port rst_i  input  1  asynchronous active-low reset.
REQ-007 The block SHALL provide port req_i  input  1  fetch request.
REQ-008 The block SHALL provide port pc_addr_i  input  ADDR_W  fetch byte address.
REQ-009 The block SHALL provide port stall_i  input  1  hold the current output, ignore req_i.
REQ-010 The block SHALL provide port instr_o  output  DATA_W  fetched instruction.
REQ-011 The block SHALL provide port valid_o  output  1  instr_o holds a fetch result.
REQ-012 The block SHALL provide port fault_o  output  2  bit0 misaligned, bit1 out-of-range.
REQ-013 The block SHALL provide port ld_en_i  input  1  program-load write enable.
REQ-014 The block SHALL provide port ld_addr_i  input  ADDR_W  load byte address.
REQ-015 The block SHALL provide port ld_data_i  input  DATA_W  load data.
REQ-016 The block SHALL provide port fetch_cnt_o  output  16  count of good fetches.

Function
REQ-017 The block SHALL compute word index = address >> log2(DATA_W/8); an address is misaligned if its low log2(DATA_W/8) bits are nonzero, and out-of-range if its index >= DEPTH.
REQ-018 The block SHALL accept a fetch at a rising edge with req_i=1 and stall_i=0; one-cycle latency: at that edge valid_o<=1 and instr_o<=mem[index].
REQ-019 The block SHALL, for an accepted fetch that is misaligned and/or out-of-range, set valid_o=1, instr_o=0 (NOP) and the matching fault_o bits (both bits may be set); for a good fetch it SHALL clear fault_o.
REQ-020 The block SHALL, at an edge with stall_i=1, hold instr_o, valid_o and fault_o unchanged; req_i is ignored, not queued.
REQ-021 The block SHALL, at an edge with req_i=0 and stall_i=0, set valid_o<=0 and fault_o<=0 while instr_o holds its last value.
REQ-022 The block SHALL, at an edge with ld_en_i=1, write ld_data_i to mem[ld index], independent of stall_i; misaligned or out-of-range loads SHALL be dropped silently.
REQ-023 The block SHALL, when a fetch and a load hit the same index at the same edge, return ld_data_i (write-first).
REQ-024 The block SHALL increment fetch_cnt_o by 1 per accepted, non-faulted fetch, saturating at 16'hFFFF.
REQ-025 The block SHALL initialise all memory words to 0 at time zero; reset SHALL NOT alter memory contents.

Reset
REQ-026 The block SHALL, while rst_i=0 and immediately (asynchronously), force valid_o=0, instr_o=0, fault_o=0 and fetch_cnt_o=0.
REQ-027 The block SHALL discard any fetch in flight when rst_i is asserted; loads are blocked while rst_i=0.
REQ-028 The block SHALL accept its first fetch or load at the first rising edge at which rst_i=1.

Verification
REQ-029 The bench SHALL cover good fetch: load 0x8C220004 at addr 0x08, then req_i=1 with pc_addr_i=0x08 -> next cycle valid_o=1, instr_o=0x8C220004, fault_o=00, fetch_cnt_o=1.
REQ-030 The bench SHALL cover faults: pc_addr_i=0x06 -> instr_o=0, fault_o=01; pc_addr_i=0x80 (DEPTH=32) -> fault_o=10; pc_addr_i=0x82 -> fault_o=11; fetch_cnt_o unchanged in all three.
REQ-031 The bench SHALL cover stall: a valid result at addr 0x04, then stall_i=1 for 3 cycles while pc_addr_i changes -> outputs frozen for all 3 cycles; after stall_i=0, the new address is returned one cycle later.
REQ-032 The bench SHALL cover collision: ld_en_i=1, ld_addr_i=0x0C, ld_data_i=0x12345678, with a fetch of 0x0C at the same edge -> instr_o=0x12345678.
REQ-033 The bench SHALL cover reset mid-operation: rst_i pulsed low between clock edges during a fetch stream -> outputs 0 at once, fetch_cnt_o=0, previously loaded words are still readable after release.
REQ-034 The bench SHALL cover saturation: 65537 good fetches -> fetch_cnt_o=16'hFFFF.
